match_ctrl: RTL

Match sequencer for the pong game. Runs the game flow through idle, serve countdown, rally, point hold, pause and game over. Keeps both scores and gates the ball and paddle motion in game_logic. Sits between game_logic, which reports scoring events and consumes the enables, and game_display, which supplies new_frame and consumes the scores and state.

---
 rtl/match_ctrl.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/match_ctrl.sv
// match_ctrl - match sequencer for the pong game.
//
// Runs the game flow (idle, serve countdown, rally, point hold, pause, game
// over), keeps both scores and gates ball/paddle motion in game_logic.
//
// Ports:
//   clk_i, rst_ni     system clock, asynchronous active-low reset
//   new_frame_i       one-cycle pulse per video frame (from game_display)
//   start_key_i       raw start button, asynchronous, active-high
//   pause_key_i       raw pause button, asynchronous, active-high
//   player_goal_i     one-cycle pulse: player scored (from game_logic)
//   enemy_goal_i      one-cycle pulse: enemy scored (from game_logic)
//   ball_en_o         ball motion enable (PLAY only)
//   paddle_en_o       paddle motion enable (SERVE or PLAY)
//   ball_reset_o      one-cycle pulse on the first cycle of every SERVE
//   serve_dir_o       0 = serve toward player, 1 = serve toward enemy
//   player_score_o    player score
//   enemy_score_o     enemy score
//   winner_o          valid in OVER: 0 = player won, 1 = enemy won
//   state_o           IDLE=0, SERVE=1, PLAY=2, POINT=3, PAUSED=4, OVER=5
module match_ctrl #(
    parameter int unsigned SCORE_W      = 4,
    parameter int unsigned WIN_SCORE    = 9,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned POINT_FRAMES = 30,
    parameter int unsigned FCNT_W       = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               new_frame_i,
    input  logic               start_key_i,
    input  logic               pause_key_i,
    input  logic               player_goal_i,
    input  logic               enemy_goal_i,
    output logic               ball_en_o,
    output logic               paddle_en_o,
    output logic               ball_reset_o,
    output logic               serve_dir_o,
    output logic [SCORE_W-1:0] player_score_o,
    output logic [SCORE_W-1:0] enemy_score_o,
    output logic               winner_o,
    output logic [2:0]         state_o
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SERVE  = 3'd1,
        ST_PLAY   = 3'd2,
        ST_POINT  = 3'd3,
        ST_PAUSED = 3'd4,
        ST_OVER   = 3'd5
    } state_e;

    localparam logic [FCNT_W-1:0]  SERVE_LAST = FCNT_W'(SERVE_FRAMES - 1);
    localparam logic [FCNT_W-1:0]  POINT_LAST = FCNT_W'(POINT_FRAMES - 1);
    localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W-1:0] ONE        = SCORE_W'(1);

    // Key conditioning: [0],[1] form the 2-FF synchroniser, [2] holds the
    // previous synchronised level for edge detection. The event itself is
    // registered, so it appears 3 cycles after the raw edge.
    logic [2:0] start_sync_q, pause_sync_q;
    logic       start_evt_q, pause_evt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            start_sync_q <= '0;
            pause_sync_q <= '0;
            start_evt_q  <= 1'b0;
            pause_evt_q  <= 1'b0;
        end else begin
            start_sync_q <= {start_sync_q[1:0], start_key_i};
            pause_sync_q <= {pause_sync_q[1:0], pause_key_i};
            start_evt_q  <= start_sync_q[1] & ~start_sync_q[2];
            pause_evt_q  <= pause_sync_q[1] & ~pause_sync_q[2];
        end
    end

    state_e             state_q, state_d;
    logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
    logic [SCORE_W-1:0] pscore_q, pscore_d;
    logic [SCORE_W-1:0] escore_q, escore_d;
    logic               dir_q, dir_d;
    logic               winner_q, winner_d;
    logic               ball_en_q, paddle_en_q, ball_reset_q;

    always_comb begin
        state_d  = state_q;
        pscore_d = pscore_q;
        escore_d = escore_q;
        dir_d    = dir_q;
        winner_d = winner_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start_evt_q) state_d = ST_SERVE;
            end
            ST_SERVE: begin
                if (new_frame_i && fcnt_q == SERVE_LAST) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                // Goals outrank pause; a double goal cancels out but still
                // ends the rally.
                if (player_goal_i && !enemy_goal_i) begin
                    pscore_d = pscore_q + ONE;
                    dir_d    = 1'b1;
                    if (pscore_d == WIN) begin
                        state_d  = ST_OVER;
                        winner_d = 1'b0;
                    end else begin
                        state_d = ST_POINT;
                    end
                end else if (enemy_goal_i && !player_goal_i) begin
                    escore_d = escore_q + ONE;
                    dir_d    = 1'b0;
                    if (escore_d == WIN) begin
                        state_d  = ST_OVER;
                        winner_d = 1'b1;
                    end else begin
                        state_d = ST_POINT;
                    end
                end else if (player_goal_i && enemy_goal_i) begin
                    state_d = ST_POINT;
                end else if (pause_evt_q) begin
                    state_d = ST_PAUSED;
                end
            end
            ST_POINT: begin
                if (new_frame_i && fcnt_q == POINT_LAST) state_d = ST_SERVE;
            end
            ST_PAUSED: begin
                if (pause_evt_q) state_d = ST_PLAY;
            end
            ST_OVER: begin
                if (start_evt_q) begin
                    pscore_d = '0;
                    escore_d = '0;
                    dir_d    = 1'b0;
                    state_d  = ST_SERVE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Frame counter restarts on every state entry and only advances
        // while a countdown state is being held.
        fcnt_d = fcnt_q;
        if (state_d != state_q) begin
            fcnt_d = '0;
        end else if (new_frame_i && (state_q == ST_SERVE || state_q == ST_POINT)) begin
            fcnt_d = fcnt_q + FCNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            fcnt_q       <= '0;
            pscore_q     <= '0;
            escore_q     <= '0;
            dir_q        <= 1'b0;
            winner_q     <= 1'b0;
            ball_en_q    <= 1'b0;
            paddle_en_q  <= 1'b0;
            ball_reset_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fcnt_q       <= fcnt_d;
            pscore_q     <= pscore_d;
            escore_q     <= escore_d;
            dir_q        <= dir_d;
            winner_q     <= winner_d;
            // Enables are registered from the next state so they line up
            // with state_o cycle for cycle.
            ball_en_q    <= (state_d == ST_PLAY);
            paddle_en_q  <= (state_d == ST_SERVE) || (state_d == ST_PLAY);
            ball_reset_q <= (state_d == ST_SERVE) && (state_q != ST_SERVE);
        end
    end

    assign ball_en_o      = ball_en_q;
    assign paddle_en_o    = paddle_en_q;
    assign ball_reset_o   = ball_reset_q;
    assign serve_dir_o    = dir_q;
    assign player_score_o = pscore_q;
    assign enemy_score_o  = escore_q;
    assign winner_o       = winner_q;
    assign state_o        = state_q;

endmodule
